// File: rtl/wrap_tracker.sv
// wrap_tracker: extends a 4-bit up/down counter with a HI_W-bit wrap count and
// queues wrap events for a downstream consumer.
//
// Ports:
//   clk, rst            single clock; asynchronous active-high reset
//   q_in, u_d_in        upstream counter value and direction (1 up, 0 down)
//   ld_in, cnt_rst_in   upstream load strobe and counter reset
//   ext_q               registered extended count {hi, q}
//   wrap_up, wrap_dn    one-cycle pulses on 15->0 / 0->15 wraps
//   evt_valid/ready     event handshake; evt_dir/evt_hi describe the head event
//   evt_ovf             sticky flag: an event was dropped on a full buffer
//
// Configuration macro WRAP_TRACKER_FIFO_EN:
//   defined   -> events go into a DEPTH-entry FIFO with valid/ready handshake
//   undefined -> single-entry register; evt_valid pulses with each wrap,
//                evt_ready is ignored and evt_ovf is tied low
module wrap_tracker #(
  parameter int unsigned HI_W  = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        q_in,
  input  logic              u_d_in,
  input  logic              ld_in,
  input  logic              cnt_rst_in,
  output logic [HI_W+3:0]   ext_q,
  output logic              wrap_up,
  output logic              wrap_dn,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic              evt_dir,
  output logic [HI_W-1:0]   evt_hi,
  output logic              evt_ovf
);

  // Previous-cycle view of the upstream counter.
  logic [3:0]      prev_q;
  logic            prev_ud;
  logic            prev_ld;
  logic            prev_crst;
  logic            prev_vld;

  logic [HI_W-1:0] hi_q;
  logic [HI_W-1:0] hi_d;
  logic            up_det;
  logic            dn_det;
  logic            up_hit;
  logic            dn_hit;
  logic            push;
  logic            wrap_up_q;
  logic            wrap_dn_q;

  always_comb begin
    up_det = prev_vld & ~prev_ld & ~prev_crst & prev_ud  &
             (prev_q == 4'hF) & (q_in == 4'h0);
    dn_det = prev_vld & ~prev_ld & ~prev_crst & ~prev_ud &
             (prev_q == 4'h0) & (q_in == 4'hF);
    // A counter reset in the same cycle wins over any wrap.
    up_hit = up_det & ~cnt_rst_in;
    dn_hit = dn_det & ~cnt_rst_in;
    push   = up_hit | dn_hit;

    hi_d = hi_q;
    if (cnt_rst_in) begin
      hi_d = '0;
    end else if (up_hit) begin
      hi_d = hi_q + HI_W'(1);
    end else if (dn_hit) begin
      hi_d = hi_q - HI_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q    <= '0;
      prev_ud   <= 1'b0;
      prev_ld   <= 1'b0;
      prev_crst <= 1'b0;
      prev_vld  <= 1'b0;
      hi_q      <= '0;
      wrap_up_q <= 1'b0;
      wrap_dn_q <= 1'b0;
    end else begin
      prev_q    <= q_in;
      prev_ud   <= u_d_in;
      prev_ld   <= ld_in;
      prev_crst <= cnt_rst_in;
      prev_vld  <= 1'b1;
      hi_q      <= hi_d;
      wrap_up_q <= up_hit;
      wrap_dn_q <= dn_hit;
    end
  end

  // prev_q already holds last cycle's q_in, so it doubles as the low nibble.
  assign ext_q   = {hi_q, prev_q};
  assign wrap_up = wrap_up_q;
  assign wrap_dn = wrap_dn_q;

`ifdef WRAP_TRACKER_FIFO_EN

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  // Entry layout: {dir, hi}.
  logic [HI_W:0]     mem [DEPTH];
  logic [PtrW-1:0]   wr_ptr;
  logic [PtrW-1:0]   rd_ptr;
  logic [CntW-1:0]   count;
  logic              full;
  logic              pop;
  logic              wr_en;
  logic              ovf_q;

  always_comb begin
    full      = (count == CntW'(DEPTH));
    evt_valid = (count != '0);
    pop       = evt_valid & evt_ready;
    // A pop on the same edge frees the slot, so a full buffer still accepts.
    wr_en     = push & (~full | pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= {up_hit, hi_d};
        wr_ptr      <= wr_ptr + PtrW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PtrW'(1);
      end
      unique case ({wr_en, pop})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase
      if (push && full && !pop) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign evt_dir = mem[rd_ptr][HI_W];
  assign evt_hi  = mem[rd_ptr][HI_W-1:0];
  assign evt_ovf = ovf_q;

`else

  logic            ev_vld_q;
  logic            ev_dir_q;
  logic [HI_W-1:0] ev_hi_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ev_vld_q <= 1'b0;
      ev_dir_q <= 1'b0;
      ev_hi_q  <= '0;
    end else begin
      ev_vld_q <= push;
      if (push) begin
        ev_dir_q <= up_hit;
        ev_hi_q  <= hi_d;
      end
    end
  end

  assign evt_valid = ev_vld_q;
  assign evt_dir   = ev_dir_q;
  assign evt_hi    = ev_hi_q;
  assign evt_ovf   = 1'b0;

  // Handshake and buffer depth have no meaning for the single-entry register.
  logic        unused_ready;
  logic [31:0] unused_depth;
  assign unused_ready = evt_ready;
  assign unused_depth = DEPTH;

`endif

endmodule

// File: tb/tb_wrap_tracker.sv
// tb_wrap_tracker: directed self-checking bench for wrap_tracker (HI_W=8, DEPTH=4).
// FIFO-specific scenarios run only when WRAP_TRACKER_FIFO_EN is defined; otherwise
// the single-entry pulse behaviour is checked instead.
module tb_wrap_tracker;

  logic        clk;
  logic        rst;
  logic [3:0]  q_in;
  logic        u_d_in;
  logic        ld_in;
  logic        cnt_rst_in;
  logic [11:0] ext_q;
  logic        wrap_up;
  logic        wrap_dn;
  logic        evt_valid;
  logic        evt_ready;
  logic        evt_dir;
  logic [7:0]  evt_hi;
  logic        evt_ovf;

  int n_cmp = 0;
  int n_bad = 0;

  wrap_tracker #(
    .HI_W  (8),
    .DEPTH (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .q_in       (q_in),
    .u_d_in     (u_d_in),
    .ld_in      (ld_in),
    .cnt_rst_in (cnt_rst_in),
    .ext_q      (ext_q),
    .wrap_up    (wrap_up),
    .wrap_dn    (wrap_dn),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_dir    (evt_dir),
    .evt_hi     (evt_hi),
    .evt_ovf    (evt_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of counter inputs, clock it, and settle 1 time unit past the edge.
  task automatic step(input logic [3:0] q, input logic ud, input logic ld, input logic crst);
    q_in       = q;
    u_d_in     = ud;
    ld_in      = ld;
    cnt_rst_in = crst;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    q_in = 4'h0; u_d_in = 1'b0; ld_in = 1'b0; cnt_rst_in = 1'b0; evt_ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (ext_q !== 12'h000) begin n_bad++; $display("FAIL reset_ext_q: got %h want 000", ext_q); end
    n_cmp++; if (wrap_up !== 1'b0 || wrap_dn !== 1'b0) begin n_bad++; $display("FAIL reset_wrap: got up=%b dn=%b want 0 0", wrap_up, wrap_dn); end
    n_cmp++; if (evt_valid !== 1'b0) begin n_bad++; $display("FAIL reset_evt_valid: got %b want 0", evt_valid); end
    n_cmp++; if (evt_ovf !== 1'b0) begin n_bad++; $display("FAIL reset_evt_ovf: got %b want 0", evt_ovf); end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_up_wrap();
    step(4'hE, 1'b1, 1'b1, 1'b0);
    n_cmp++; if (ext_q !== 12'h00E) begin n_bad++; $display("FAIL up_load_ext_q: got %h want 00E", ext_q); end
    step(4'hF, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (wrap_up !== 1'b0) begin n_bad++; $display("FAIL up_pre_wrap: got %b want 0", wrap_up); end
    step(4'h0, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (wrap_up !== 1'b1 || wrap_dn !== 1'b0) begin n_bad++; $display("FAIL up_pulse: got up=%b dn=%b want 1 0", wrap_up, wrap_dn); end
    n_cmp++; if (ext_q !== 12'h010) begin n_bad++; $display("FAIL up_ext_q: got %h want 010", ext_q); end
    n_cmp++; if (evt_valid !== 1'b1 || evt_dir !== 1'b1 || evt_hi !== 8'h01) begin n_bad++; $display("FAIL up_evt: got v=%b d=%b hi=%h want 1 1 01", evt_valid, evt_dir, evt_hi); end
  endtask

  task automatic test_down_wrap();
    step(4'h0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (wrap_up !== 1'b0 || ext_q !== 12'h010) begin n_bad++; $display("FAIL dn_hold: got up=%b ext=%h want 0 010", wrap_up, ext_q); end
    n_cmp++; if (evt_valid !== 1'b0) begin n_bad++; $display("FAIL dn_evt_gone: got %b want 0", evt_valid); end
    step(4'hF, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (wrap_dn !== 1'b1 || wrap_up !== 1'b0) begin n_bad++; $display("FAIL dn_pulse: got up=%b dn=%b want 0 1", wrap_up, wrap_dn); end
    n_cmp++; if (ext_q !== 12'h00F) begin n_bad++; $display("FAIL dn_ext_q: got %h want 00F", ext_q); end
    n_cmp++; if (evt_valid !== 1'b1 || evt_dir !== 1'b0 || evt_hi !== 8'h00) begin n_bad++; $display("FAIL dn_evt: got v=%b d=%b hi=%h want 1 0 00", evt_valid, evt_dir, evt_hi); end
  endtask

  task automatic test_load();
    logic [3:0]  qs  [4];
    logic        uds [4];
    logic        lds [4];
    logic [11:0] exp [4];
    qs = '{4'hF, 4'h0, 4'hF, 4'h0};
    uds = '{1'b1, 1'b1, 1'b0, 1'b1};
    lds = '{1'b1, 1'b1, 1'b1, 1'b0};
    exp = '{12'h00F, 12'h000, 12'h00F, 12'h000};
    for (int i = 0; i < 4; i++) begin
      step(qs[i], uds[i], lds[i], 1'b0);
      n_cmp++;
      if (wrap_up !== 1'b0 || wrap_dn !== 1'b0 || evt_valid !== 1'b0 || ext_q !== exp[i]) begin
        n_bad++;
        $display("FAIL load_%0d: got up=%b dn=%b v=%b ext=%h want 0 0 0 %h", i, wrap_up, wrap_dn, evt_valid, ext_q, exp[i]);
      end
    end
  endtask

  task automatic test_modulo();
    int ups;
    step(4'h0, 1'b0, 1'b0, 1'b0);
    step(4'hF, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (wrap_dn !== 1'b1 || ext_q !== 12'hFFF) begin n_bad++; $display("FAIL mod_under: got dn=%b ext=%h want 1 FFF", wrap_dn, ext_q); end
    n_cmp++; if (evt_hi !== 8'hFF) begin n_bad++; $display("FAIL mod_under_evt: got %h want FF", evt_hi); end
    step(4'hF, 1'b1, 1'b0, 1'b0);
    step(4'h0, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (wrap_up !== 1'b1 || ext_q !== 12'h000) begin n_bad++; $display("FAIL mod_over: got up=%b ext=%h want 1 000", wrap_up, ext_q); end
    ups = 0;
    for (int i = 0; i < 256; i++) begin
      step(4'hF, 1'b1, 1'b0, 1'b0);
      step(4'h0, 1'b1, 1'b0, 1'b0);
      if (wrap_up === 1'b1) ups++;
      if (i == 127) begin
        n_cmp++; if (ext_q !== 12'h800) begin n_bad++; $display("FAIL mod_mid: got %h want 800", ext_q); end
      end
    end
    n_cmp++; if (ups != 256) begin n_bad++; $display("FAIL mod_pulses: got %0d want 256", ups); end
    n_cmp++; if (ext_q !== 12'h000) begin n_bad++; $display("FAIL mod_round: got %h want 000", ext_q); end
  endtask

  task automatic test_cnt_rst();
    step(4'hF, 1'b1, 1'b0, 1'b0);
    step(4'h0, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (ext_q !== 12'h010) begin n_bad++; $display("FAIL crst_pre: got %h want 010", ext_q); end
    step(4'hF, 1'b1, 1'b0, 1'b0);
    step(4'h0, 1'b1, 1'b0, 1'b1);
    n_cmp++; if (wrap_up !== 1'b0 || evt_valid !== 1'b0 || ext_q !== 12'h000) begin n_bad++; $display("FAIL crst_wrap: got up=%b v=%b ext=%h want 0 0 000", wrap_up, evt_valid, ext_q); end
    step(4'h0, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (wrap_up !== 1'b0 || ext_q !== 12'h000) begin n_bad++; $display("FAIL crst_after: got up=%b ext=%h want 0 000", wrap_up, ext_q); end
    step(4'hF, 1'b1, 1'b0, 1'b0);
    step(4'h0, 1'b1, 1'b0, 1'b0);
    step(4'h5, 1'b1, 1'b0, 1'b1);
    n_cmp++; if (ext_q !== 12'h005) begin n_bad++; $display("FAIL crst_clear: got %h want 005", ext_q); end
  endtask

`ifdef WRAP_TRACKER_FIFO_EN
  task automatic test_fifo();
    evt_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(4'hF, 1'b1, 1'b0, 1'b0);
      step(4'h0, 1'b1, 1'b0, 1'b0);
      if (i == 3) begin
        n_cmp++; if (evt_ovf !== 1'b0) begin n_bad++; $display("FAIL fifo_no_ovf: got %b want 0", evt_ovf); end
      end
    end
    n_cmp++; if (evt_ovf !== 1'b1) begin n_bad++; $display("FAIL fifo_ovf: got %b want 1", evt_ovf); end
    step(4'h1, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (evt_valid !== 1'b1 || evt_hi !== 8'h01) begin n_bad++; $display("FAIL fifo_hold: got v=%b hi=%h want 1 01", evt_valid, evt_hi); end
    evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++;
      if (evt_valid !== 1'b1 || evt_dir !== 1'b1 || evt_hi !== 8'(i + 1)) begin
        n_bad++;
        $display("FAIL fifo_drain_%0d: got v=%b d=%b hi=%h want 1 1 %h", i, evt_valid, evt_dir, evt_hi, 8'(i + 1));
      end
      step(4'h1, 1'b1, 1'b0, 1'b0);
    end
    n_cmp++; if (evt_valid !== 1'b0 || evt_ovf !== 1'b1) begin n_bad++; $display("FAIL fifo_empty: got v=%b ovf=%b want 0 1", evt_valid, evt_ovf); end
  endtask
`else
  task automatic test_pulse();
    evt_ready = 1'b0;
    step(4'hF, 1'b1, 1'b0, 1'b0);
    step(4'h0, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (evt_valid !== 1'b1 || evt_dir !== 1'b1 || evt_hi !== 8'h01) begin n_bad++; $display("FAIL pulse_evt: got v=%b d=%b hi=%h want 1 1 01", evt_valid, evt_dir, evt_hi); end
    step(4'h1, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (evt_valid !== 1'b0 || evt_ovf !== 1'b0) begin n_bad++; $display("FAIL pulse_drop: got v=%b ovf=%b want 0 0", evt_valid, evt_ovf); end
    n_cmp++; if (evt_hi !== 8'h01) begin n_bad++; $display("FAIL pulse_hold: got %h want 01", evt_hi); end
  endtask
`endif

  task automatic test_reset_mid();
    evt_ready = 1'b0;
    step(4'hF, 1'b1, 1'b0, 1'b0);
    step(4'h0, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (evt_valid !== 1'b1) begin n_bad++; $display("FAIL rmid_pre: got %b want 1", evt_valid); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (evt_valid !== 1'b0 || evt_ovf !== 1'b0) begin n_bad++; $display("FAIL rmid_evt: got v=%b ovf=%b want 0 0", evt_valid, evt_ovf); end
    n_cmp++; if (ext_q !== 12'h000 || wrap_up !== 1'b0) begin n_bad++; $display("FAIL rmid_ext: got ext=%h up=%b want 000 0", ext_q, wrap_up); end
    @(posedge clk);
    #1 rst = 1'b0;
    // Reset leaves prev = (0, down); a 15 now would look like a down wrap.
    step(4'hF, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (wrap_dn !== 1'b0 || ext_q !== 12'h00F || evt_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_first: got dn=%b ext=%h v=%b want 0 00F 0", wrap_dn, ext_q, evt_valid); end
    step(4'h0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (wrap_up !== 1'b0 || wrap_dn !== 1'b0 || ext_q !== 12'h000) begin n_bad++; $display("FAIL rmid_second: got up=%b dn=%b ext=%h want 0 0 000", wrap_up, wrap_dn, ext_q); end
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_load();
    test_modulo();
    test_cnt_rst();
`ifdef WRAP_TRACKER_FIFO_EN
    test_fifo();
`else
    test_pulse();
`endif
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
